// File: rtl/flaf_pkg.sv
// -----------------------------------------------------------------------------
// flaf_pkg
// Shared definitions for the functional-link adaptive filter weight-update
// control path: sequencer state encoding, default numeric format of the
// mu-scaled error sample, and a ceil(log2) helper for sizing tap indices.
// -----------------------------------------------------------------------------
package flaf_pkg;

    // Default data format shared with the multiply/update datapath.
    localparam int FLAF_WIDTH = 16;
    localparam int FLAF_FRAC  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Smallest r with 2**r >= n (bounded loop so it stays a constant function).
    function automatic int flaf_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/flaf_tag_pipe.sv
// -----------------------------------------------------------------------------
// flaf_tag_pipe
// PIPE-deep delay line carrying {valid, idx}. It runs in lock-step with the
// datapath pipeline so every issued tap re-emerges as a writeback strobe with
// its own index exactly PIPE cycles later. The valid bit is cleared by reset
// so nothing in flight survives an abort.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low clear
//   valid_i  in   issue strobe entering the pipe
//   idx_i    in   tap index entering the pipe
//   valid_o  out  issue strobe delayed by PIPE cycles
//   idx_o    out  tap index delayed by PIPE cycles
// -----------------------------------------------------------------------------
module flaf_tag_pipe #(
    parameter int PIPE = 2,
    parameter int IDXW = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [IDXW-1:0] idx_i,
    output logic            valid_o,
    output logic [IDXW-1:0] idx_o
);

    logic            vld_q [PIPE];
    logic [IDXW-1:0] idx_q [PIPE];

    // Shifts every cycle; stalls upstream simply inject invalid bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < PIPE; i++) begin
                vld_q[i] <= 1'b0;
                idx_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= valid_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < PIPE; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[PIPE-1];
    assign idx_o   = idx_q[PIPE-1];

endmodule

// File: rtl/flaf_wupdate_sched.sv
// -----------------------------------------------------------------------------
// flaf_wupdate_sched
// Sequencer/arbiter for the shared weight-update multiplier. Latches a new
// mu-scaled error sample, issues one tap update per cycle (yielding to the
// forward path whenever it asks for the multiplier), and tags each issue so
// the writeback strobe/index emerge PIPE cycles later.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_ni         in   asynchronous active-low reset
//   err_valid_i    in   new mu*error sample strobe
//   mu_a_error_i   in   mu-scaled error sample
//   fwd_req_i      in   forward path wants the multiplier this cycle
//   clr_ovr_i      in   clear sticky overrun flag
//   ready_o        out  a new sample can be accepted this cycle
//   busy_o         out  sweep in progress (issue or drain)
//   err_hold_o     out  latched error sample, stable during a sweep
//   fwd_gnt_o      out  multiplier granted to forward path
//   upd_en_o       out  datapath issue strobe
//   tap_idx_o      out  tap being issued
//   wb_en_o        out  datapath result valid
//   wb_idx_o       out  tap index of the writeback
//   done_o         out  one-cycle pulse after the last writeback
//   overrun_o      out  sticky: sample arrived while not ready
// -----------------------------------------------------------------------------
module flaf_wupdate_sched
    import flaf_pkg::*;
#(
    parameter int WIDTH = FLAF_WIDTH,
    parameter int FRAC  = FLAF_FRAC,
    parameter int NTAPS = 8,
    parameter int PIPE  = 2,
    parameter int IDXW  = flaf_clog2(NTAPS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             err_valid_i,
    input  logic [WIDTH-1:0] mu_a_error_i,
    input  logic             fwd_req_i,
    input  logic             clr_ovr_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] err_hold_o,
    output logic             fwd_gnt_o,
    output logic             upd_en_o,
    output logic [IDXW-1:0]  tap_idx_o,
    output logic             wb_en_o,
    output logic [IDXW-1:0]  wb_idx_o,
    output logic             done_o,
    output logic             overrun_o
);

    // Reject configurations the sequencer cannot serve at elaboration time.
    if (FRAC > WIDTH || NTAPS < 2 || PIPE < 1 || (1 << IDXW) < NTAPS) begin : g_param_check
        $error("flaf_wupdate_sched: illegal parameter combination");
    end

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic             ovr_q, ovr_d;

    logic             accept;
    logic             issue;
    logic             last_issue;
    logic             last_wb;
    logic             tag_valid;
    logic [IDXW-1:0]  tag_idx;

    // A sample is taken only in IDLE or DONE; DONE may chain straight into
    // the next sweep without an IDLE bubble.
    assign accept     = err_valid_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign issue      = (state_q == ST_ISSUE) && !fwd_req_i;
    assign last_issue = issue && (cnt_q == LAST_IDX);
    // Writebacks leave the pipe in issue order, so the final index marks
    // the end of the drain.
    assign last_wb    = tag_valid && (tag_idx == LAST_IDX);

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (last_wb) state_d = ST_DONE;
            ST_DONE:  state_d = accept ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        ready_o   = (state_q == ST_IDLE) || (state_q == ST_DONE);
        busy_o    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
        done_o    = (state_q == ST_DONE);
        fwd_gnt_o = fwd_req_i;
        upd_en_o  = issue;
        tap_idx_o = issue ? cnt_q : '0;
    end

    // ---------------- counter / sample / overrun ----------------
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (issue && !last_issue) begin
            // Holds at LAST_IDX after the final issue, so it never wraps.
            cnt_d = cnt_q + 1'b1;
        end

        err_d = accept ? mu_a_error_i : err_q;

        // A new overrun outranks a simultaneous clear.
        ovr_d = ovr_q;
        if (err_valid_i && !accept) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            ovr_q <= ovr_d;
        end
    end

    assign err_hold_o = err_q;
    assign overrun_o  = ovr_q;

    flaf_tag_pipe #(
        .PIPE (PIPE),
        .IDXW (IDXW)
    ) u_tag_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (issue),
        .idx_i   (cnt_q),
        .valid_o (tag_valid),
        .idx_o   (tag_idx)
    );

    assign wb_en_o  = tag_valid;
    assign wb_idx_o = tag_idx;

endmodule

// File: tb/tb_flaf_wupdate_sched.sv
// -----------------------------------------------------------------------------
// tb_flaf_wupdate_sched
// Scoreboard bench: directed stimulus pushes hand-computed expectations
// (event cycle + index, or a sampled level at a given cycle) into a queue; a
// monitor on the falling edge pops and compares whenever a DUT shows an
// event. DUT A uses defaults; DUT B is the NTAPS=2 / PIPE=1 variant.
// -----------------------------------------------------------------------------
module tb_flaf_wupdate_sched;

    localparam int K_UPD  = 0;
    localparam int K_WB   = 1;
    localparam int K_DONE = 2;
    localparam int K_HOLD = 3;
    localparam int K_OVR  = 4;
    localparam int K_RDY  = 5;
    localparam int K_BUSY = 6;
    localparam int K_GNT  = 7;

    typedef struct {
        int          dut;
        int          kind;
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // DUT A (defaults)
    logic        a_ev = 0, a_fwd = 0, a_clr = 0;
    logic [15:0] a_mu = '0;
    logic        a_ready, a_busy, a_gnt, a_upd, a_wb, a_done, a_ovr;
    logic [15:0] a_hold;
    logic [2:0]  a_tap, a_wbi;

    // DUT B (NTAPS=2, PIPE=1)
    logic        b_ev = 0, b_fwd = 0, b_clr = 0;
    logic [15:0] b_mu = '0;
    logic        b_ready, b_busy, b_gnt, b_upd, b_wb, b_done, b_ovr;
    logic [15:0] b_hold;
    logic [0:0]  b_tap, b_wbi;

    flaf_wupdate_sched u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .err_valid_i(a_ev), .mu_a_error_i(a_mu),
        .fwd_req_i(a_fwd), .clr_ovr_i(a_clr), .ready_o(a_ready), .busy_o(a_busy),
        .err_hold_o(a_hold), .fwd_gnt_o(a_gnt), .upd_en_o(a_upd), .tap_idx_o(a_tap),
        .wb_en_o(a_wb), .wb_idx_o(a_wbi), .done_o(a_done), .overrun_o(a_ovr)
    );

    flaf_wupdate_sched #(.NTAPS(2), .PIPE(1), .IDXW(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .err_valid_i(b_ev), .mu_a_error_i(b_mu),
        .fwd_req_i(b_fwd), .clr_ovr_i(b_clr), .ready_o(b_ready), .busy_o(b_busy),
        .err_hold_o(b_hold), .fwd_gnt_o(b_gnt), .upd_en_o(b_upd), .tap_idx_o(b_tap),
        .wb_en_o(b_wb), .wb_idx_o(b_wbi), .done_o(b_done), .overrun_o(b_ovr)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_UPD:   return "upd";
            K_WB:    return "wb";
            K_DONE:  return "done";
            K_HOLD:  return "err_hold";
            K_OVR:   return "overrun";
            K_RDY:   return "ready";
            K_BUSY:  return "busy";
            default: return "fwd_gnt";
        endcase
    endfunction

    function automatic bit ev_on(int d, int k);
        if (d == 0) begin
            case (k)
                K_UPD:   return a_upd === 1'b1;
                K_WB:    return a_wb === 1'b1;
                default: return a_done === 1'b1;
            endcase
        end
        case (k)
            K_UPD:   return b_upd === 1'b1;
            K_WB:    return b_wb === 1'b1;
            default: return b_done === 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ev_val(int d, int k);
        if (k == K_UPD) return (d == 0) ? 32'(a_tap) : 32'(b_tap);
        if (k == K_WB)  return (d == 0) ? 32'(a_wbi) : 32'(b_wbi);
        return 32'd0;
    endfunction

    function automatic logic [31:0] snap(int d, int k);
        if (d == 0) begin
            case (k)
                K_HOLD:  return 32'(a_hold);
                K_OVR:   return 32'(a_ovr);
                K_RDY:   return 32'(a_ready);
                K_BUSY:  return 32'(a_busy);
                default: return 32'(a_gnt);
            endcase
        end
        case (k)
            K_HOLD:  return 32'(b_hold);
            K_OVR:   return 32'(b_ovr);
            K_RDY:   return 32'(b_ready);
            K_BUSY:  return 32'(b_busy);
            default: return 32'(b_gnt);
        endcase
    endfunction

    task automatic compare(input string name, input int d, input logic [31:0] act,
                           input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h, required %0h", name, d, cyc, act, req);
        end else begin
            $display("ok   %s dut%0d cyc=%0d: %0h", name, d, cyc, act);
        end
    endtask

    task automatic push(input int d, input int k, input int c, input logic [31:0] v);
        exp_t e;
        e.dut = d; e.kind = k; e.cyc = c; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full stall-free sweep of DUT A with err_valid accepted at cycle s.
    task automatic push_sweep_a(input int s);
        for (int t = 0; t < 8; t++) begin
            push(0, K_UPD, s + 1 + t, t);
            push(0, K_WB,  s + 3 + t, t);
        end
        push(0, K_DONE, s + 11, 0);
    endtask

    // Monitor: pops the oldest matching event expectation per observed event,
    // and checks level expectations due this cycle.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int k = K_UPD; k <= K_DONE; k++) begin
                if (ev_on(d, k)) begin
                    int f;
                    f = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (f < 0 && exp_q[i].dut == d && exp_q[i].kind == k) f = i;
                    end
                    if (f < 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL %s dut%0d cyc=%0d: unexpected event idx=%0h, required none",
                                 kname(k), d, cyc, ev_val(d, k));
                    end else begin
                        compare({kname(k), "_cycle"}, d, 32'(cyc), 32'(exp_q[f].cyc));
                        if (k != K_DONE) compare({kname(k), "_idx"}, d, ev_val(d, k), exp_q[f].val);
                        exp_q.delete(f);
                    end
                end
            end
        end
        begin
            int i;
            i = 0;
            while (i < exp_q.size()) begin
                if (exp_q[i].kind >= K_HOLD && exp_q[i].cyc == cyc) begin
                    compare(kname(exp_q[i].kind), exp_q[i].dut,
                            snap(exp_q[i].dut, exp_q[i].kind), exp_q[i].val);
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    int T, T2, T3, T4;

    initial begin
        // ---------------- reset state ----------------
        to_cyc(2);
        for (int d = 0; d < 2; d++) begin
            compare("rst_ready", d, snap(d, K_RDY), 1);
            compare("rst_busy",  d, snap(d, K_BUSY), 0);
            compare("rst_hold",  d, snap(d, K_HOLD), 0);
            compare("rst_ovr",   d, snap(d, K_OVR), 0);
            compare("rst_upd",   d, 32'(ev_on(d, K_UPD)), 0);
            compare("rst_wb",    d, 32'(ev_on(d, K_WB)), 0);
            compare("rst_done",  d, 32'(ev_on(d, K_DONE)), 0);
        end
        rst_n = 1'b1;

        // ---------------- 1: plain sweep ----------------
        T = 5;
        push_sweep_a(T);
        push(0, K_HOLD, T + 1, 32'h0A3C);
        push(0, K_RDY,  T + 1, 0);
        push(0, K_BUSY, T + 9, 1);
        push(0, K_RDY,  T + 11, 1);
        push(0, K_BUSY, T + 11, 0);
        push(0, K_RDY,  T + 12, 1);
        to_cyc(T); a_ev = 1; a_mu = 16'h0A3C;
        to_cyc(T + 1); a_ev = 0;

        // ---------- 2: stalls, overrun, chained sample in DONE ----------
        T2 = T + 20;
        for (int t = 0; t < 8; t++) begin
            int u;
            u = (t < 2) ? T2 + 1 + t : T2 + 3 + t;
            push(0, K_UPD, u, t);
            push(0, K_WB,  u + 2, t);
        end
        push(0, K_DONE, T2 + 13, 0);
        push(0, K_GNT,  T2 + 3, 1);
        push(0, K_GNT,  T2 + 4, 1);
        push(0, K_GNT,  T2 + 5, 0);
        push(0, K_OVR,  T2 + 6, 1);
        push(0, K_HOLD, T2 + 8, 32'h0A3C);
        push(0, K_OVR,  T2 + 19, 1);
        push(0, K_RDY,  T2 + 13, 1);
        push_sweep_a(T2 + 13);
        push(0, K_HOLD, T2 + 14, 32'h0200);
        push(0, K_RDY,  T2 + 14, 0);
        push(0, K_BUSY, T2 + 14, 1);
        push(0, K_OVR,  T2 + 21, 0);
        push(0, K_OVR,  T2 + 23, 1);
        push(0, K_HOLD, T2 + 23, 32'h0200);
        push(0, K_OVR,  T2 + 26, 0);
        push(0, K_GNT,  T2 + 27, 1);

        to_cyc(T2);      a_ev = 1; a_mu = 16'h0A3C;
        to_cyc(T2 + 1);  a_ev = 0;
        to_cyc(T2 + 3);  a_fwd = 1;
        to_cyc(T2 + 5);  a_fwd = 0; a_ev = 1; a_mu = 16'h1111;
        to_cyc(T2 + 6);  a_ev = 0;
        to_cyc(T2 + 13); a_ev = 1; a_mu = 16'h0200;
        to_cyc(T2 + 14); a_ev = 0;
        to_cyc(T2 + 20); a_clr = 1;
        to_cyc(T2 + 21); a_clr = 0;
        to_cyc(T2 + 22); a_clr = 1; a_ev = 1; a_mu = 16'h3333;
        to_cyc(T2 + 23); a_clr = 0; a_ev = 0;
        to_cyc(T2 + 25); a_clr = 1;
        to_cyc(T2 + 26); a_clr = 0;
        to_cyc(T2 + 27); a_fwd = 1;
        to_cyc(T2 + 28); a_fwd = 0;

        // ---------------- 3: asynchronous reset mid-sweep ----------------
        T3 = T2 + 32;
        for (int t = 0; t < 5; t++) push(0, K_UPD, T3 + 1 + t, t);
        for (int t = 0; t < 3; t++) push(0, K_WB,  T3 + 3 + t, t);
        push(0, K_OVR, T3 + 4, 1);
        to_cyc(T3);     a_ev = 1; a_mu = 16'h0555;
        to_cyc(T3 + 1); a_ev = 0;
        to_cyc(T3 + 3); a_ev = 1; a_mu = 16'h1234;
        to_cyc(T3 + 4); a_ev = 0;
        to_cyc(T3 + 6);
        #2 rst_n = 1'b0;
        #1;
        compare("arst_ready", 0, snap(0, K_RDY), 1);
        compare("arst_busy",  0, snap(0, K_BUSY), 0);
        compare("arst_hold",  0, snap(0, K_HOLD), 0);
        compare("arst_ovr",   0, snap(0, K_OVR), 0);
        compare("arst_upd",   0, 32'(ev_on(0, K_UPD)), 0);
        compare("arst_wb",    0, 32'(ev_on(0, K_WB)), 0);
        compare("arst_done",  0, 32'(ev_on(0, K_DONE)), 0);
        to_cyc(T3 + 8); rst_n = 1'b1;
        push_sweep_a(T3 + 10);
        push(0, K_HOLD, T3 + 11, 32'h0777);
        to_cyc(T3 + 10); a_ev = 1; a_mu = 16'h0777;
        to_cyc(T3 + 11); a_ev = 0;

        // ---------------- 4: NTAPS=2, PIPE=1 variant ----------------
        T4 = T3 + 25;
        push(1, K_UPD,  T4 + 1, 0);
        push(1, K_UPD,  T4 + 2, 1);
        push(1, K_WB,   T4 + 2, 0);
        push(1, K_WB,   T4 + 3, 1);
        push(1, K_DONE, T4 + 4, 0);
        push(1, K_HOLD, T4 + 1, 32'h0100);
        push(1, K_RDY,  T4 + 4, 1);
        push(1, K_BUSY, T4 + 3, 1);
        to_cyc(T4);     b_ev = 1; b_mu = 16'h0100;
        to_cyc(T4 + 1); b_ev = 0;

        to_cyc(T4 + 8);
        compare("pending_expectations", 0, 32'(exp_q.size()), 0);
        foreach (exp_q[i]) begin
            $display("  still pending: dut%0d %s cyc=%0d val=%0h",
                     exp_q[i].dut, kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/flaf_wupdate_sched.md
Name: flaf_wupdate_sched

Overview:
- Sequencer and arbiter for the shared weight-update datapath of the functional-link adaptive filter.
- One pipelined multiply/update unit serves all NTAPS weights. This block latches each new mu-scaled error sample and issues one tap update per cycle to the datapath.
- It tags each issue so the matching writeback strobe and index line up after the datapath latency.
- The forward (filter-output) path shares the same multiplier and has priority over update issue.

Parameters:
- WIDTH, 16, data width of the error sample (Q(WIDTH-FRAC).FRAC).
- FRAC, 12, fractional bits; passed through to the datapath, not used internally.
- NTAPS, 8, number of weights updated per error sample (>=2).
- PIPE, 2, datapath latency in cycles from upd_en to result valid (>=1).
- IDXW, 3, tap index width; must satisfy 2**IDXW >= NTAPS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- err_valid  in  1  new mu*error sample present (single-cycle strobe).
- mu_a_error  in  WIDTH  mu-scaled error sample, sampled with err_valid.
- fwd_req  in  1  forward path requests the shared multiplier this cycle.
- clr_ovr  in  1  clears the sticky overrun flag.
- ready  out  1  block can accept err_valid this cycle.
- busy  out  1  update sweep in progress.
- err_hold  out  WIDTH  latched error, held stable to the datapath during a sweep.
- fwd_gnt  out  1  multiplier granted to the forward path.
- upd_en  out  1  datapath issue strobe for tap tap_idx.
- tap_idx  out  IDXW  tap being issued.
- wb_en  out  1  datapath result valid; write back weight wb_idx.
- wb_idx  out  IDXW  tap index of the current writeback.
- done  out  1  one-cycle pulse; all NTAPS writebacks complete.
- overrun  out  1  sticky: err_valid arrived while not ready.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all outputs 0 except ready=1. err_hold=0, counters=0, tag pipe cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: ready=1. On err_valid, latch mu_a_error into err_hold, clear issue count, go to ISSUE.
- ISSUE: busy=1.
  - fwd_req=1: fwd_gnt=1, upd_en=0, issue count holds (stall).
  - fwd_req=0: upd_en=1, tap_idx=count, count++.
  - After issuing tap NTAPS-1, go to DRAIN.
- DRAIN: busy=1, no issue. Move to DONE in the cycle after the last wb_en.
- DONE: done=1, busy=0, ready=1. An err_valid here latches and goes straight to ISSUE; otherwise go to IDLE.
- Arbitration: fwd_gnt=fwd_req in every state (forward always wins). Outside ISSUE, fwd_gnt simply echoes fwd_req.
- Writeback tagging: a PIPE-deep shift register of {valid, idx} advances every cycle regardless of stalls.
  - wb_en/wb_idx appear exactly PIPE cycles after the matching upd_en/tap_idx.
  - wb_idx order is strictly 0..NTAPS-1.
- err_hold changes only on an accepted err_valid, never mid-sweep.
- Overrun: err_valid while ready=0 drops the sample and sets overrun=1. It stays set until clr_ovr=1. If clr_ovr and a new overrun occur in the same cycle, set wins.
- Count wrap: the issue count never exceeds NTAPS-1; no wrap when NTAPS < 2**IDXW.
- Reset mid-sweep: pending writebacks are discarded (wb_en=0) and no done pulse is issued.
- Latency with no stalls, err_valid accepted at cycle 0:
  - upd_en cycles 1..NTAPS.
  - wb_en cycles 1+PIPE..NTAPS+PIPE.
  - done at NTAPS+PIPE+1.

Decomposition:
- Shared package flaf_pkg holds:
  - state encoding typedef (IDLE/ISSUE/DRAIN/DONE);
  - default WIDTH/FRAC constants shared with the datapath;
  - a clog2 helper for IDXW.
- One natural sub-module: flaf_tag_pipe, a PIPE-deep {valid, idx} delay line with async active-low clear. It is separate from the datapath's own DelayNUnit because it must carry a valid bit.

Test Plan:
- Defaults, reset released, err_valid with mu_a_error=16'h0A3C at cycle 0, fwd_req=0 -> err_hold=0A3C; upd_en cycles 1..8 with tap_idx 0..7; wb_en cycles 3..10 with wb_idx 0..7; done at cycle 11 only; ready=1 at 11.
- Same start, fwd_req=1 on cycles 3 and 4 -> fwd_gnt=1 and upd_en=0 on 3,4; tap 2 is issued at cycle 5; last upd_en at cycle 10; done at cycle 13; wb_idx sequence unbroken.
- err_valid at cycle 5 mid-sweep with value 16'h1111 -> ignored, err_hold stays 0A3C, overrun=1 until clr_ovr pulse at cycle 20 -> overrun=0 at 21.
- err_valid with 16'h0200 in the done cycle (cycle 11) -> no IDLE visit; upd_en tap 0 at cycle 12; err_hold=0200.
- reset asserted asynchronously at cycle 6 -> all outputs 0 immediately, ready=1; no wb_en/done after release; next err_valid starts a clean sweep from tap 0.
- PIPE=1, NTAPS=2 variant -> upd_en at cycles 1,2; wb_en at 2,3; done at 4.
